// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and the oversample divider helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam int OVS = 16;
  localparam int DATA_BITS = 8;
  localparam int MID_SAMPLE = 7;
  function automatic int ovs_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVS);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: rx pin, byte holding register handshake (data_o/valid_o/ack_i) and status (frame_err_o, overrun_o/err_clr_i, busy_o)
interface uart_rx_if;
  logic rx;
  logic [7:0] data_o;
  logic valid_o;
  logic ack_i;
  logic frame_err_o;
  logic overrun_o;
  logic err_clr_i;
  logic busy_o;
  modport master (input rx, ack_i, err_clr_i, output data_o, valid_o, frame_err_o, overrun_o, busy_o);
  modport slave (output rx, ack_i, err_clr_i, input data_o, valid_o, frame_err_o, overrun_o, busy_o);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 0..DIV-1 divider; clk/rst, restart zeroes the count, tick is high on the wrap cycle
module uart_baud_tick #(parameter int DIV = 54) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] div_q;
  assign tick = div_q == W'(DIV - 1);
  always_ff @(posedge clk)
    if (rst || restart || tick) div_q <= '0;
    else div_q <= div_q + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 16x-oversampled receiver; clk/rst plain, bus carries rx, data_o/valid_o/ack_i, frame_err_o, overrun_o/err_clr_i, busy_o
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD = 115200,
  parameter int OVS_DIV = ovs_div(CLK_FREQ, BAUD)
) (
  input logic clk,
  input logic rst,
  uart_rx_if.master bus
);
  state_t state, state_n;
  logic [1:0] sync;
  logic rx_s, tick, deliver;
  logic [3:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] sh, sh_n;
  assign rx_s = sync[1];
  uart_baud_tick #(.DIV(OVS_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .restart(state == IDLE && !rx_s),
    .tick(tick)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bit_n = bit_idx;
    sh_n = sh;
    deliver = 1'b0;
    case (state)
      IDLE: if (!rx_s) begin
        state_n = START;
        cnt_n = '0;
      end
      START: if (tick) begin
        cnt_n = cnt + 1'b1;
        if (cnt == 4'(MID_SAMPLE)) begin
          state_n = rx_s ? IDLE : DATA;
          cnt_n = '0;
          bit_n = '0;
        end
      end
      DATA: if (tick) begin
        cnt_n = cnt + 1'b1;
        if (cnt == 4'(OVS - 1)) begin
          sh_n = {rx_s, sh[7:1]};
          bit_n = bit_idx + 1'b1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            state_n = STOP;
            cnt_n = '0;
          end
        end
      end
      STOP: if (tick) begin
        cnt_n = cnt + 1'b1;
        if (cnt == 4'(OVS - 1)) begin
          deliver = 1'b1;
          state_n = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      bus.data_o <= '0;
      bus.valid_o <= 1'b0;
      bus.frame_err_o <= 1'b0;
      bus.overrun_o <= 1'b0;
      bus.busy_o <= 1'b0;
    end else begin
      sync <= {sync[0], bus.rx};
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      sh <= sh_n;
      bus.busy_o <= state_n != IDLE;
      if (deliver && (!bus.valid_o || bus.ack_i)) begin
        bus.data_o <= sh;
        bus.frame_err_o <= !rx_s;
        bus.valid_o <= 1'b1;
      end else if (bus.ack_i) bus.valid_o <= 1'b0;
      bus.overrun_o <= (deliver && bus.valid_o && !bus.ack_i) || (bus.overrun_o && !bus.err_clr_i);
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a holding-register reference model
module tb_uart_rx;
  localparam int BIT = 64;
  localparam int RISE = 611;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic m_valid, m_fe, m_ovr;
  logic [7:0] m_data;
  uart_rx_if bus();
  uart_rx #(.OVS_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic ack;
    bus.ack_i = 1'b1;
    @(negedge clk);
    bus.ack_i = 1'b0;
    m_valid = 1'b0;
  endtask
  task automatic clr;
    bus.err_clr_i = 1'b1;
    @(negedge clk);
    bus.err_clr_i = 1'b0;
    m_ovr = 1'b0;
  endtask
  function automatic int model_frame(input logic [7:0] b, input logic stop);
    if (m_valid) begin
      m_ovr = 1'b1;
      return -1;
    end
    m_valid = 1'b1;
    m_data = b;
    m_fe = !stop;
    return RISE;
  endfunction
  task automatic send_frame(input logic [7:0] b, input logic stop, input int clr_at, output int rise);
    logic [9:0] f;
    logic prev;
    f = {stop, b, 1'b0};
    rise = -1;
    prev = bus.valid_o;
    for (int k = 0; k < 10 * BIT; k++) begin
      bus.rx = f[k / BIT];
      bus.err_clr_i = (k == clr_at);
      @(negedge clk);
      if (rise < 0 && !prev && bus.valid_o) rise = k + 1;
      prev = bus.valid_o;
    end
    bus.err_clr_i = 1'b0;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    int r, er, seen;
    logic [7:0] b;
    logic s;
    logic [9:0] f;
    bus.rx = 1'b1;
    bus.ack_i = 1'b0;
    bus.err_clr_i = 1'b0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_fe = 1'b0;
    m_data = '0;
    idle(5);
    check("rst_data", bus.data_o, 0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_fe", bus.frame_err_o, 0);
    check("rst_ovr", bus.overrun_o, 0);
    check("rst_busy", bus.busy_o, 0);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen |= int'(bus.busy_o);
    end
    check("post_rst_busy", seen, 0);
    send_frame(8'hA5, 1'b1, -1, r);
    check("a5_rise", r, RISE);
    check("a5_data", bus.data_o, 8'hA5);
    check("a5_fe", bus.frame_err_o, 0);
    ack;
    check("a5_ack", bus.valid_o, 0);
    bus.rx = 1'b0;
    idle(16);
    bus.rx = 1'b1;
    check("glitch_busy", bus.busy_o, 1);
    idle(60);
    check("glitch_idle", bus.busy_o, 0);
    check("glitch_valid", bus.valid_o, 0);
    send_frame(8'h3C, 1'b0, -1, r);
    bus.rx = 1'b0;
    idle(200);
    check("fe_rise", r, RISE);
    check("fe_data", bus.data_o, 8'h3C);
    check("fe_flag", bus.frame_err_o, 1);
    check("fe_break", bus.busy_o, 1);
    bus.rx = 1'b1;
    idle(4);
    check("fe_exit", bus.busy_o, 0);
    check("fe_once", bus.overrun_o, 0);
    check("fe_valid", bus.valid_o, 1);
    ack;
    send_frame(8'h11, 1'b1, -1, r);
    check("ov1_rise", r, RISE);
    send_frame(8'h22, 1'b1, -1, r);
    check("ov2_rise", r, -1);
    check("ov_data", bus.data_o, 8'h11);
    check("ov_fe", bus.frame_err_o, 0);
    check("ov_flag", bus.overrun_o, 1);
    ack;
    check("ov_ack", bus.valid_o, 0);
    check("ov_sticky", bus.overrun_o, 1);
    clr;
    check("ov_clr", bus.overrun_o, 0);
    send_frame(8'h44, 1'b1, -1, r);
    send_frame(8'h55, 1'b1, RISE - 1, r);
    check("ov_set_wins", bus.overrun_o, 1);
    check("ov_data2", bus.data_o, 8'h44);
    ack;
    clr;
    f = {1'b1, 8'hC3, 1'b0};
    for (int k = 0; k < 352; k++) begin
      bus.rx = f[k / BIT];
      @(negedge clk);
    end
    check("mid_busy", bus.busy_o, 1);
    rst = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", bus.busy_o, 0);
    idle(20);
    check("mid_no_valid", bus.valid_o, 0);
    send_frame(8'h5A, 1'b1, -1, r);
    check("5a_rise", r, RISE);
    check("5a_data", bus.data_o, 8'h5A);
    ack;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      s = $urandom_range(3) != 0;
      if ($urandom_range(1) == 1) ack;
      if ($urandom_range(3) == 0) clr;
      er = model_frame(b, s);
      send_frame(b, s, -1, r);
      bus.rx = 1'b1;
      idle($urandom_range(40, 1));
      check("rnd_rise", r, er);
      check("rnd_valid", bus.valid_o, m_valid);
      check("rnd_data", bus.data_o, m_data);
      check("rnd_fe", bus.frame_err_o, m_fe);
      check("rnd_ovr", bus.overrun_o, m_ovr);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
